// File: rtl/modport_alu.sv
`default_nettype none
// ============================================================================
//  Module      : modport_alu
//  Description : Registered ALU with clock enable and per-operand valid
//                qualifiers. MODE=1 selects the arithmetic command set and
//                MODE=0 the logical set. RES and the status flags (OFLOW,
//                COUT, E, G, L, ERR) are registered one cycle after an
//                enabled edge and hold while CE is low.
//                Optional feature macro: ALU_SIGNED_EN adds the signed
//                arithmetic commands SADD (11) and SSUB (12).
//  Revision    : 1.0 - initial release
// ============================================================================
module modport_alu #(
  parameter int WIDTH     = 8,
  parameter int CMD_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   OPA,
  input  logic [WIDTH-1:0]   OPB,
  input  logic [CMD_WIDTH:0] CMD,
  input  logic               CIN,
  input  logic               CE,
  input  logic               MODE,
  input  logic [1:0]         INP_VALID,
  output logic [WIDTH:0]     RES,
  output logic               OFLOW,
  output logic               COUT,
  output logic               E,
  output logic               G,
  output logic               L,
  output logic               ERR
);

  // Rotate amount width; B bits above index SHW are the out-of-range field.
  localparam int SHW = $clog2(WIDTH);

  // Arithmetic command codes (MODE = 1)
  localparam logic [CMD_WIDTH:0] c_A_ADD     = 'd0;
  localparam logic [CMD_WIDTH:0] c_A_SUB     = 'd1;
  localparam logic [CMD_WIDTH:0] c_A_ADD_CIN = 'd2;
  localparam logic [CMD_WIDTH:0] c_A_SUB_CIN = 'd3;
  localparam logic [CMD_WIDTH:0] c_A_INC_A   = 'd4;
  localparam logic [CMD_WIDTH:0] c_A_DEC_A   = 'd5;
  localparam logic [CMD_WIDTH:0] c_A_INC_B   = 'd6;
  localparam logic [CMD_WIDTH:0] c_A_DEC_B   = 'd7;
  localparam logic [CMD_WIDTH:0] c_A_CMP     = 'd8;
  localparam logic [CMD_WIDTH:0] c_A_INC_MUL = 'd9;
  localparam logic [CMD_WIDTH:0] c_A_SHL_MUL = 'd10;
`ifdef ALU_SIGNED_EN
  localparam logic [CMD_WIDTH:0] c_A_SADD    = 'd11;
  localparam logic [CMD_WIDTH:0] c_A_SSUB    = 'd12;
`endif

  // Logical command codes (MODE = 0)
  localparam logic [CMD_WIDTH:0] c_L_AND     = 'd0;
  localparam logic [CMD_WIDTH:0] c_L_NAND    = 'd1;
  localparam logic [CMD_WIDTH:0] c_L_OR      = 'd2;
  localparam logic [CMD_WIDTH:0] c_L_NOR     = 'd3;
  localparam logic [CMD_WIDTH:0] c_L_XOR     = 'd4;
  localparam logic [CMD_WIDTH:0] c_L_XNOR    = 'd5;
  localparam logic [CMD_WIDTH:0] c_L_NOT_A   = 'd6;
  localparam logic [CMD_WIDTH:0] c_L_NOT_B   = 'd7;
  localparam logic [CMD_WIDTH:0] c_L_SHR1_A  = 'd8;
  localparam logic [CMD_WIDTH:0] c_L_SHL1_A  = 'd9;
  localparam logic [CMD_WIDTH:0] c_L_SHR1_B  = 'd10;
  localparam logic [CMD_WIDTH:0] c_L_SHL1_B  = 'd11;
  localparam logic [CMD_WIDTH:0] c_L_ROL_A_B = 'd12;
  localparam logic [CMD_WIDTH:0] c_L_ROR_A_B = 'd13;

  // Operand-requirement masks, compared against INP_VALID
  localparam logic [1:0] c_NEED_A    = 2'b01;
  localparam logic [1:0] c_NEED_B    = 2'b10;
  localparam logic [1:0] c_NEED_BOTH = 2'b11;

  localparam logic [WIDTH:0] c_ONE      = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [SHW:0]   c_WIDTH_SH = WIDTH[SHW:0];

  // Registered outputs and their next-state values
  logic [WIDTH:0] res_q;
  logic [WIDTH:0] res_d;
  logic           oflow_q;
  logic           oflow_d;
  logic           cout_q;
  logic           cout_d;
  logic           e_q;
  logic           e_d;
  logic           g_q;
  logic           g_d;
  logic           l_q;
  logic           l_d;
  logic           err_q;
  logic           err_d;

  // Command decode results
  logic [1:0]     w_need;
  logic           w_legal;
  logic           w_ops_ok;

  // Shared datapath terms
  logic [WIDTH:0]   w_a;
  logic [WIDTH:0]   w_b;
  logic [WIDTH:0]   w_cin_ext;
  logic [WIDTH:0]   w_b_cin;
  logic [WIDTH:0]   w_a_inc;
  logic [WIDTH:0]   w_b_inc;
  logic [WIDTH:0]   w_a_shl;
  logic [SHW-1:0]   w_sh;
  logic [SHW:0]     w_sh_inv;
  logic [WIDTH-1:0] w_rol;
  logic [WIDTH-1:0] w_ror;
  logic             w_b_hi_set;

  // Operands zero-extended to the result width so carries/borrows land in
  // RES[WIDTH] and truncation to WIDTH+1 bits falls out of the arithmetic.
  assign w_a       = {1'b0, OPA};
  assign w_b       = {1'b0, OPB};
  assign w_cin_ext = {{WIDTH{1'b0}}, CIN};
  assign w_b_cin   = w_b + w_cin_ext;
  assign w_a_inc   = w_a + c_ONE;
  assign w_b_inc   = w_b + c_ONE;
  assign w_a_shl   = {OPA, 1'b0};

  // Rotates: the complementary shift by WIDTH-k supplies the wrapped bits;
  // a shift by WIDTH (k = 0) yields zero, so rotate-by-0 returns A.
  assign w_sh       = OPB[SHW-1:0];
  assign w_sh_inv   = c_WIDTH_SH - {1'b0, w_sh};
  assign w_rol      = (OPA << w_sh) | (OPA >> w_sh_inv);
  assign w_ror      = (OPA >> w_sh) | (OPA << w_sh_inv);
  assign w_b_hi_set = (OPB >> (SHW + 1)) != '0;

`ifdef ALU_SIGNED_EN
  // Signed operands sign-extended into the result width
  logic [WIDTH:0] w_sa;
  logic [WIDTH:0] w_sb;
  logic [WIDTH:0] w_ssum;
  logic [WIDTH:0] w_sdif;
  logic           w_sadd_ovf;
  logic           w_ssub_ovf;

  assign w_sa   = {OPA[WIDTH-1], OPA};
  assign w_sb   = {OPB[WIDTH-1], OPB};
  assign w_ssum = w_sa + w_sb;
  assign w_sdif = w_sa - w_sb;
  // Overflow when the WIDTH-bit result sign disagrees with what the operand
  // signs allow (equal signs for add, opposite signs for subtract).
  assign w_sadd_ovf = (OPA[WIDTH-1] == OPB[WIDTH-1]) && (w_ssum[WIDTH-1] != OPA[WIDTH-1]);
  assign w_ssub_ovf = (OPA[WIDTH-1] != OPB[WIDTH-1]) && (w_sdif[WIDTH-1] != OPA[WIDTH-1]);
`endif

  // Decode command legality and which operands it consumes
  always_comb begin
    w_legal = 1'b1;
    w_need  = c_NEED_BOTH;
    if (MODE) begin
      case (CMD)
        c_A_ADD, c_A_SUB, c_A_ADD_CIN, c_A_SUB_CIN,
        c_A_CMP, c_A_INC_MUL, c_A_SHL_MUL: w_need = c_NEED_BOTH;
        c_A_INC_A, c_A_DEC_A:              w_need = c_NEED_A;
        c_A_INC_B, c_A_DEC_B:              w_need = c_NEED_B;
`ifdef ALU_SIGNED_EN
        c_A_SADD, c_A_SSUB:                w_need = c_NEED_BOTH;
`endif
        default:                           w_legal = 1'b0;
      endcase
    end else begin
      case (CMD)
        c_L_AND, c_L_NAND, c_L_OR, c_L_NOR, c_L_XOR, c_L_XNOR,
        c_L_ROL_A_B, c_L_ROR_A_B:          w_need = c_NEED_BOTH;
        c_L_NOT_A, c_L_SHR1_A, c_L_SHL1_A: w_need = c_NEED_A;
        c_L_NOT_B, c_L_SHR1_B, c_L_SHL1_B: w_need = c_NEED_B;
        default:                           w_legal = 1'b0;
      endcase
    end
  end

  assign w_ops_ok = (INP_VALID & w_need) == w_need;

  // Next-state datapath: clear everything, then set only the fields the command defines
  always_comb begin
    res_d   = '0;
    oflow_d = 1'b0;
    cout_d  = 1'b0;
    e_d     = 1'b0;
    g_d     = 1'b0;
    l_d     = 1'b0;
    err_d   = 1'b0;
    if (!w_legal || !w_ops_ok) begin
      err_d = 1'b1;
    end else if (MODE) begin
      case (CMD)
        c_A_ADD: begin
          res_d  = w_a + w_b;
          cout_d = res_d[WIDTH];
        end
        c_A_SUB: begin
          res_d   = w_a - w_b;
          oflow_d = (OPA < OPB);
        end
        c_A_ADD_CIN: begin
          res_d  = w_a + w_b + w_cin_ext;
          cout_d = res_d[WIDTH];
        end
        c_A_SUB_CIN: begin
          res_d   = w_a - w_b_cin;
          oflow_d = (w_a < w_b_cin);
        end
        c_A_INC_A: res_d = w_a_inc;
        c_A_DEC_A: res_d = w_a - c_ONE;
        c_A_INC_B: res_d = w_b_inc;
        c_A_DEC_B: res_d = w_b - c_ONE;
        c_A_CMP: begin
          e_d = (OPA == OPB);
          g_d = (OPA > OPB);
          l_d = (OPA < OPB);
        end
        // Only the low WIDTH+1 product bits are kept, so a WIDTH+1-bit
        // multiply is sufficient.
        c_A_INC_MUL: res_d = w_a_inc * w_b_inc;
        c_A_SHL_MUL: res_d = w_a_shl * w_b;
`ifdef ALU_SIGNED_EN
        c_A_SADD: begin
          res_d   = w_ssum;
          oflow_d = w_sadd_ovf;
          e_d     = (OPA == OPB);
          g_d     = ($signed(OPA) > $signed(OPB));
          l_d     = ($signed(OPA) < $signed(OPB));
        end
        c_A_SSUB: begin
          res_d   = w_sdif;
          oflow_d = w_ssub_ovf;
          e_d     = (OPA == OPB);
          g_d     = ($signed(OPA) > $signed(OPB));
          l_d     = ($signed(OPA) < $signed(OPB));
        end
`endif
        default: err_d = 1'b1;
      endcase
    end else begin
      case (CMD)
        c_L_AND:    res_d = {1'b0, OPA & OPB};
        c_L_NAND:   res_d = {1'b0, ~(OPA & OPB)};
        c_L_OR:     res_d = {1'b0, OPA | OPB};
        c_L_NOR:    res_d = {1'b0, ~(OPA | OPB)};
        c_L_XOR:    res_d = {1'b0, OPA ^ OPB};
        c_L_XNOR:   res_d = {1'b0, ~(OPA ^ OPB)};
        c_L_NOT_A:  res_d = {1'b0, ~OPA};
        c_L_NOT_B:  res_d = {1'b0, ~OPB};
        c_L_SHR1_A: res_d = {1'b0, OPA >> 1};
        c_L_SHL1_A: res_d = {1'b0, OPA << 1};
        c_L_SHR1_B: res_d = {1'b0, OPB >> 1};
        c_L_SHL1_B: res_d = {1'b0, OPB << 1};
        // Out-of-range rotate amounts flag ERR but still produce a result.
        c_L_ROL_A_B: begin
          res_d = {1'b0, w_rol};
          err_d = w_b_hi_set;
        end
        c_L_ROR_A_B: begin
          res_d = {1'b0, w_ror};
          err_d = w_b_hi_set;
        end
        default: err_d = 1'b1;
      endcase
    end
  end

  // Output registers: reset wins over CE; CE low holds the last result
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q   <= '0;
      oflow_q <= 1'b0;
      cout_q  <= 1'b0;
      e_q     <= 1'b0;
      g_q     <= 1'b0;
      l_q     <= 1'b0;
      err_q   <= 1'b0;
    end else if (CE) begin
      res_q   <= res_d;
      oflow_q <= oflow_d;
      cout_q  <= cout_d;
      e_q     <= e_d;
      g_q     <= g_d;
      l_q     <= l_d;
      err_q   <= err_d;
    end
  end

  assign RES   = res_q;
  assign OFLOW = oflow_q;
  assign COUT  = cout_q;
  assign E     = e_q;
  assign G     = g_q;
  assign L     = l_q;
  assign ERR   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_modport_alu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_modport_alu
//  Description : Self-checking bench for modport_alu (WIDTH=8, CMD_WIDTH=3).
//                An integer-arithmetic reference model predicts the
//                registered outputs every cycle; directed vectors pin the
//                model with hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_modport_alu;

  typedef struct packed {
    logic [8:0] res;
    logic       oflow;
    logic       cout;
    logic       e;
    logic       g;
    logic       l;
    logic       err;
  } out_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] opa;
  logic [7:0] opb;
  logic [3:0] cmd;
  logic       cin;
  logic       ce;
  logic       mode;
  logic [1:0] vld;
  logic [8:0] res;
  logic       oflow;
  logic       cout;
  logic       e;
  logic       g;
  logic       l;
  logic       err;

  out_t act;
  out_t exp_q;
  bit   chk_en = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  modport_alu #(.WIDTH(8), .CMD_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .OPA(opa), .OPB(opb), .CMD(cmd), .CIN(cin),
    .CE(ce), .MODE(mode), .INP_VALID(vld), .RES(res), .OFLOW(oflow),
    .COUT(cout), .E(e), .G(g), .L(l), .ERR(err)
  );

  always #5 clk = ~clk;

  assign act = {res, oflow, cout, e, g, l, err};

  // Reference model: outputs that must follow an enabled edge with these inputs
  function automatic out_t model(input int a, input int b, input int c,
                                 input int ci, input bit md, input int v);
    out_t r;
    int   need;
    int   x;
    int   sa;
    int   sb;
    int   k;
    r    = '0;
    need = 0;
    sa   = (a >= 128) ? a - 256 : a;
    sb   = (b >= 128) ? b - 256 : b;
    if (md) begin
      if (c <= 3 || c == 8 || c == 9 || c == 10) need = 3;
      else if (c == 4 || c == 5) need = 1;
      else if (c == 6 || c == 7) need = 2;
`ifdef ALU_SIGNED_EN
      else if (c == 11 || c == 12) need = 3;
`endif
    end else begin
      if (c <= 5 || c == 12 || c == 13) need = 3;
      else if (c == 6 || c == 8 || c == 9) need = 1;
      else if (c == 7 || c == 10 || c == 11) need = 2;
    end
    if (need == 0 || (v & need) != need) begin
      r.err = 1'b1;
      return r;
    end
    x = 0;
    if (md) begin
      case (c)
        0:  begin x = a + b;      r.cout  = (x > 255); end
        1:  begin x = a - b;      r.oflow = (a < b); end
        2:  begin x = a + b + ci; r.cout  = (x > 255); end
        3:  begin x = a - b - ci; r.oflow = (a < b + ci); end
        4:  x = a + 1;
        5:  x = a - 1;
        6:  x = b + 1;
        7:  x = b - 1;
        8:  begin r.e = (a == b); r.g = (a > b); r.l = (a < b); end
        9:  x = (a + 1) * (b + 1);
        10: x = (2 * a) * b;
        11: begin
          x = sa + sb;
          r.oflow = (x > 127 || x < -128);
          r.e = (sa == sb); r.g = (sa > sb); r.l = (sa < sb);
        end
        default: begin
          x = sa - sb;
          r.oflow = (x > 127 || x < -128);
          r.e = (sa == sb); r.g = (sa > sb); r.l = (sa < sb);
        end
      endcase
      r.res = x[8:0];
    end else begin
      k = b % 8;
      case (c)
        0:  x = a & b;
        1:  x = ~(a & b);
        2:  x = a | b;
        3:  x = ~(a | b);
        4:  x = a ^ b;
        5:  x = ~(a ^ b);
        6:  x = ~a;
        7:  x = ~b;
        8:  x = a / 2;
        9:  x = a * 2;
        10: x = b / 2;
        11: x = b * 2;
        12: begin x = (a << k) | (a >> (8 - k)); r.err = (b >= 16); end
        default: begin x = (a >> k) | (a << (8 - k)); r.err = (b >= 16); end
      endcase
      r.res = {1'b0, x[7:0]};
    end
    return r;
  endfunction

  function automatic out_t mk(input logic [8:0] r, input logic of, input logic co,
                              input logic e_, input logic g_, input logic l_,
                              input logic er);
    mk = {r, of, co, e_, g_, l_, er};
  endfunction

  // Model state tracks the DUT's registered outputs edge by edge
  always @(posedge clk) begin
    if (rst) exp_q <= '0;
    else if (ce) exp_q <= model(int'(opa), int'(opb), int'(cmd), int'(cin), mode, int'(vld));
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (act !== exp_q) begin
        n_bad++;
        $display("FAIL model_cmp t=%0t mode=%0d cmd=%0d: actual res=%h of/co/e/g/l/err=%b%b%b%b%b%b required res=%h of/co/e/g/l/err=%b%b%b%b%b%b",
                 $time, mode, cmd, act.res, act.oflow, act.cout, act.e, act.g, act.l, act.err,
                 exp_q.res, exp_q.oflow, exp_q.cout, exp_q.e, exp_q.g, exp_q.l, exp_q.err);
      end
    end
  end

  task automatic lit(input string nm, input out_t req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual res=%h of/co/e/g/l/err=%b%b%b%b%b%b required res=%h of/co/e/g/l/err=%b%b%b%b%b%b",
               nm, act.res, act.oflow, act.cout, act.e, act.g, act.l, act.err,
               req.res, req.oflow, req.cout, req.e, req.g, req.l, req.err);
    end
  endtask

  // Apply one vector for one clock, then return at the following negedge
  task automatic step(input logic r, input logic en, input logic md, input logic [3:0] c,
                      input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input logic [1:0] v);
    rst = r; ce = en; mode = md; cmd = c; opa = a; opb = b; cin = ci; vld = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_rand(input logic r, input logic en);
    step(r, en, 1'($urandom), 4'($urandom), 8'($urandom), 8'($urandom),
         1'($urandom), 2'($urandom));
  endtask

  logic [7:0] tab_a [6] = '{8'h00, 8'hFF, 8'h80, 8'h35, 8'h9A, 8'h5A};
  logic [7:0] tab_b [6] = '{8'h00, 8'hFF, 8'h7F, 8'hC4, 8'h13, 8'hF3};
  logic       tab_c [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [1:0] tab_v [6] = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b10, 2'b11};

  initial begin
    rst = 1'b1; ce = 1'b1; mode = 1'b0; cmd = '0; opa = '0; opb = '0; cin = 1'b0; vld = '0;

    // Reset with random inputs and CE high
    for (int i = 0; i < 2; i++) begin
      step_rand(1'b1, 1'b1);
      lit("reset_clear", '0);
      chk_en = 1'b1;
    end
    // CE low after reset: outputs stay cleared while inputs change
    for (int i = 0; i < 3; i++) begin
      step_rand(1'b0, 1'b0);
      lit("ce0_after_reset", '0);
    end

    step(0, 1, 1, 4'd2, 8'hFF, 8'h01, 1, 2'b11);
    lit("add_cin", mk(9'h101, 0, 1, 0, 0, 0, 0));
    step(0, 1, 1, 4'd1, 8'h03, 8'h05, 0, 2'b11);
    lit("sub_borrow", mk(9'h1FE, 1, 0, 0, 0, 0, 0));
    step(0, 1, 1, 4'd8, 8'h07, 8'h07, 0, 2'b11);
    lit("cmp_equal", mk(9'h000, 0, 0, 1, 0, 0, 0));
    step(0, 1, 1, 4'd0, 8'h12, 8'h34, 0, 2'b01);
    lit("add_missing_b", mk(9'h000, 0, 0, 0, 0, 0, 1));
    step(0, 1, 1, 4'd4, 8'h0F, 8'hAA, 0, 2'b01);
    lit("inc_a_a_only", mk(9'h010, 0, 0, 0, 0, 0, 0));
    step(0, 1, 0, 4'd12, 8'h81, 8'h01, 0, 2'b11);
    lit("rol_by_1", mk(9'h003, 0, 0, 0, 0, 0, 0));
    step(0, 1, 0, 4'd12, 8'h81, 8'h11, 0, 2'b11);
    lit("rol_b_out_of_range", mk(9'h003, 0, 0, 0, 0, 0, 1));
    step(0, 1, 0, 4'd15, 8'h81, 8'h11, 0, 2'b11);
    lit("logic_illegal", mk(9'h000, 0, 0, 0, 0, 0, 1));
    step(0, 1, 0, 4'd13, 8'h81, 8'h00, 0, 2'b11);
    lit("ror_by_0", mk(9'h081, 0, 0, 0, 0, 0, 0));
    step(0, 1, 0, 4'd12, 8'hA5, 8'h08, 0, 2'b11);
    lit("rol_bit3_ignored", mk(9'h0A5, 0, 0, 0, 0, 0, 0));
    step(0, 1, 1, 4'd5, 8'h00, 8'h00, 0, 2'b01);
    lit("dec_a_zero", mk(9'h1FF, 0, 0, 0, 0, 0, 0));
    step(0, 1, 1, 4'd0, 8'hFF, 8'h01, 0, 2'b11);
    lit("add_255_1", mk(9'h100, 0, 1, 0, 0, 0, 0));
    step(0, 0, 1, 4'd1, 8'h03, 8'h05, 0, 2'b11);
    lit("ce0_hold", mk(9'h100, 0, 1, 0, 0, 0, 0));
    step(0, 1, 1, 4'd9, 8'h02, 8'h03, 0, 2'b11);
    lit("inc_mul", mk(9'h00C, 0, 0, 0, 0, 0, 0));
    step(0, 1, 1, 4'd3, 8'h05, 8'h05, 1, 2'b11);
    lit("sub_cin_borrow", mk(9'h1FF, 1, 0, 0, 0, 0, 0));
    step(0, 1, 1, 4'd11, 8'h7F, 8'h01, 0, 2'b11);
`ifdef ALU_SIGNED_EN
    lit("sadd_overflow", mk(9'h080, 1, 0, 0, 1, 0, 0));
`else
    lit("cmd11_illegal", mk(9'h000, 0, 0, 0, 0, 0, 1));
`endif
    step(0, 1, 1, 4'd13, 8'h7F, 8'h01, 0, 2'b11);
    lit("arith_illegal", mk(9'h000, 0, 0, 0, 0, 0, 1));
    step(0, 1, 1, 4'd0, 8'hFF, 8'h01, 0, 2'b11);
    step(1, 1, 1, 4'd0, 8'hFF, 8'h01, 0, 2'b11);
    lit("reset_over_ce", '0);

    // Command sweep over both modes and a small operand table
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 16; c++) begin
        for (int t = 0; t < 6; t++) begin
          step(0, 1, 1'(m), 4'(c), tab_a[t], tab_b[t], tab_c[t], tab_v[t]);
        end
      end
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
